sweep_ctrl: RTL
===============

Name: sweep_ctrl

Overview:
- Sequencing controller for the signal-generator phase counter (enable plus 8-bit increment).
- Steps the counter's `incr` from a start value to a stop value in fixed increments, holding each value for a programmable number of enabled cycles. This produces a frequency sweep (chirp) at the ROM output.
- Sits between the config/top level and the counter: drives the counter's `en` and `incr` directly.

Parameters:
- WIDTH, 8, width of increment values (start/stop/step/incr).
- DWELL_W, 16, width of the dwell-length input and internal dwell counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  1-cycle request to begin a sweep; sampled only in IDLE
- abort  input  1  terminate sweep immediately
- pause  input  1  level; freezes sweep while high
- loop  input  1  1 = repeat sweep, 0 = single sweep; latched at start
- start_incr  input  WIDTH  first increment value; latched at start
- stop_incr  input  WIDTH  last allowed increment value; latched at start
- step  input  WIDTH  amount added to incr per step; latched at start
- dwell  input  DWELL_W  enabled cycles per incr value, 0 treated as 1; latched at start
- en  output  1  counter enable
- incr  output  WIDTH  counter increment
- busy  output  1  high in RUN
- done  output  1  1-cycle pulse on single-sweep completion
- step_tick  output  1  1-cycle pulse on every incr update after the first

Behaviour:
- Reset (async, any time):
  - state = IDLE; en = 0; incr = 0; busy = 0; done = 0; step_tick = 0.
  - Dwell counter = 0; latched config cleared.
- States are IDLE and RUN. All outputs are registered.
- Start:
  - IDLE with start=1 and abort=0: latch config.
  - Next cycle: state = RUN, incr = start_incr, en = !pause, busy = 1, dwell counter = 0.
  - start while in RUN is ignored.
- Dwell counting:
  - In RUN with pause=0: en = 1 and the dwell counter increments each cycle.
  - When the counter reaches max(dwell,1)-1 it clears and a step decision is made. Each incr value is therefore output with en=1 for exactly max(dwell,1) cycles.
- Step decision:
  - Compute nxt = incr + step in WIDTH+1 bits (no wrap).
  - If nxt <= stop_incr: incr = nxt and step_tick = 1.
  - Else, if loop=1: incr = start_incr and step_tick = 1.
  - Else, if loop=0: next cycle state = IDLE, en = 0, busy = 0, done = 1 for one cycle, and incr holds its last value.
- Pause:
  - While pause=1 in RUN: en = 0, dwell counter frozen, incr held.
  - On release, counting resumes from the frozen value. Paused cycles do not count toward dwell.
- Abort:
  - Highest priority after rst. In any state, next cycle: state = IDLE, en = 0, busy = 0, incr = 0, done = 0, step_tick = 0.
  - abort and start in the same cycle: abort wins and no sweep starts.
- Boundary conditions:
  - start_incr > stop_incr: start_incr is output for one dwell. Then single mode finishes and loop mode re-emits start_incr with step_tick.
  - step = 0: nxt == incr, so incr is held indefinitely, with step_tick each dwell, until abort.
  - Overflow: nxt is compared at WIDTH+1 bits. An incr that would exceed 2^WIDTH-1 is treated as past stop and is never truncated.
  - Config inputs changing during RUN have no effect until the next start.
- Latency:
  - start to first en=1: 1 cycle.
  - Last enabled cycle to done: 1 cycle.

Optional Feature:
- Macro: SWEEP_PINGPONG_EN.
- Defined:
  - In loop mode, the controller reverses direction at each end instead of wrapping.
  - Up phase: stops at the last value <= stop_incr.
  - Down phase: subtracts step, computed in WIDTH+1 bits; a result below start_incr reverses direction again.
  - The endpoint value is not repeated; each reversal asserts step_tick.
  - Single mode is unchanged.
- Undefined: loop mode wraps to start_incr as specified above, and no direction state exists.

Test Plan:
- Basic sweep: rst, then start with start_incr=2, stop_incr=8, step=3, dwell=4, loop=0 -> incr 2,5,8 each with en=1 for 4 cycles; step_tick twice; done one cycle after the 12th enabled cycle; en=0, busy=0 after.
- Loop: same config with loop=1 -> sequence 2,5,8,2,5,... with no done. Under SWEEP_PINGPONG_EN: 2,5,8,5,2,5.
- Pause: dwell=4, pause high for 3 cycles after the 2nd enabled cycle -> en=0 for those 3 cycles; incr value lasts 4 enabled cycles (7 total).
- Abort: abort at cycle 6 of RUN -> next cycle en=0, incr=0, busy=0, no done; abort+start same cycle in IDLE -> stays IDLE.
- Edges: start_incr=250, stop_incr=255, step=10, WIDTH=8 -> single value 250 then done (no wrap to 4); dwell=0 -> each value 1 cycle; step=0 -> incr stuck, step_tick every dwell.
- Async reset mid-RUN (between clock edges) -> all outputs 0 immediately; a new start afterwards runs a normal sweep.

Source files
------------

// File: rtl/sweep_ctrl.sv
// Sweep sequencer for the phase counter: steps incr from start to stop, holding each value for a dwell.
// Optional SWEEP_PINGPONG_EN makes loop mode bounce between the endpoints instead of wrapping.
module sweep_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic               loop,
    input  logic [WIDTH-1:0]   start_incr,
    input  logic [WIDTH-1:0]   stop_incr,
    input  logic [WIDTH-1:0]   step,
    input  logic [DWELL_W-1:0] dwell,
    output logic               en,
    output logic [WIDTH-1:0]   incr,
    output logic               busy,
    output logic               done,
    output logic               step_tick
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic [WIDTH-1:0]   incr_q, incr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               step_tick_q, step_tick_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] last_q, last_d;
    logic               loop_q, loop_d;
    logic [WIDTH-1:0]   start_q, start_d;
    logic [WIDTH-1:0]   stop_q, stop_d;
    logic [WIDTH-1:0]   step_q, step_d;

    // One extra bit so a sum past 2^WIDTH-1 compares as beyond stop instead of wrapping.
    logic [WIDTH:0] up_sum;
    logic           up_ok;

    assign up_sum = {1'b0, incr_q} + {1'b0, step_q};
    assign up_ok  = (up_sum <= {1'b0, stop_q});

`ifdef SWEEP_PINGPONG_EN
    logic           dir_q, dir_d;   // 1 = descending
    logic [WIDTH:0] dn_diff;
    logic           dn_ok;

    assign dn_diff = {1'b0, incr_q} - {1'b0, step_q};
    assign dn_ok   = !dn_diff[WIDTH] && (dn_diff[WIDTH-1:0] >= start_q);
`endif

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        incr_d      = incr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        step_tick_d = 1'b0;
        cnt_d       = cnt_q;
        last_d      = last_q;
        loop_d      = loop_q;
        start_d     = start_q;
        stop_d      = stop_q;
        step_d      = step_q;
`ifdef SWEEP_PINGPONG_EN
        dir_d       = dir_q;
`endif
        if (abort) begin
            state_d = IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            incr_d  = '0;
        end else if (state_q == IDLE) begin
            en_d   = 1'b0;
            busy_d = 1'b0;
            if (start) begin
                loop_d  = loop;
                start_d = start_incr;
                stop_d  = stop_incr;
                step_d  = step;
                last_d  = (dwell == '0) ? '0 : dwell - 1'b1;
                state_d = RUN;
                incr_d  = start_incr;
                en_d    = !pause;
                busy_d  = 1'b1;
                cnt_d   = '0;
`ifdef SWEEP_PINGPONG_EN
                dir_d   = 1'b0;
`endif
            end
        end else begin
            en_d = !pause;
            // Only cycles actually presented with en=1 count toward the dwell.
            if (en_q) begin
                if (cnt_q == last_q) begin
                    cnt_d = '0;
`ifdef SWEEP_PINGPONG_EN
                    if (loop_q && dir_q) begin
                        step_tick_d = 1'b1;
                        if (dn_ok) begin
                            incr_d = dn_diff[WIDTH-1:0];
                        end else if (up_ok) begin
                            incr_d = up_sum[WIDTH-1:0];
                            dir_d  = 1'b0;
                        end else begin
                            incr_d = start_q;
                            dir_d  = 1'b0;
                        end
                    end else if (up_ok) begin
                        incr_d      = up_sum[WIDTH-1:0];
                        step_tick_d = 1'b1;
                    end else if (loop_q) begin
                        step_tick_d = 1'b1;
                        if (dn_ok) begin
                            incr_d = dn_diff[WIDTH-1:0];
                            dir_d  = 1'b1;
                        end else begin
                            incr_d = start_q;
                        end
                    end else begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
`else
                    if (up_ok) begin
                        incr_d      = up_sum[WIDTH-1:0];
                        step_tick_d = 1'b1;
                    end else if (loop_q) begin
                        incr_d      = start_q;
                        step_tick_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            incr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            step_tick_q <= 1'b0;
            cnt_q       <= '0;
            last_q      <= '0;
            loop_q      <= 1'b0;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
`ifdef SWEEP_PINGPONG_EN
            dir_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            incr_q      <= incr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            step_tick_q <= step_tick_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            loop_q      <= loop_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            step_q      <= step_d;
`ifdef SWEEP_PINGPONG_EN
            dir_q       <= dir_d;
`endif
        end
    end

    assign en        = en_q;
    assign incr      = incr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign step_tick = step_tick_q;

endmodule
